// File: rtl/simd_sequencer.sv
// SIMD run controller: owns the program counter and the fetch/issue rhythm.
// One zero-overhead hardware loop, external stall, drain before done.
module simd_sequencer #(
    parameter int INS_ADDR_WIDTH = 10,
    parameter int LOOP_CNT_WIDTH = 8,
    parameter int DRAIN_CYCLES   = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [INS_ADDR_WIDTH:0]   prog_len,
    input  logic                      loop_en,
    input  logic [INS_ADDR_WIDTH-1:0] loop_start,
    input  logic [INS_ADDR_WIDTH-1:0] loop_end,
    input  logic [LOOP_CNT_WIDTH-1:0] loop_count,
    input  logic                      ext_stall,
    output logic [INS_ADDR_WIDTH-1:0] pc,
    output logic                      ins_rd_en,
    output logic                      issue_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int AW = INS_ADDR_WIDTH;
    localparam int CW = LOOP_CNT_WIDTH;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW:0]     last_q, last_d;
    logic [AW-1:0]   lst_q, lst_d;
    logic [AW-1:0]   lend_q, lend_d;
    logic            lact_q, lact_d;
    logic [CW-1:0]   iter_q, iter_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            busy_q, busy_d;
    logic            cfg_err_q, cfg_err_d;
    logic            cfg_act;

    // Loop config is usable only if the body lies inside the program.
    assign cfg_act = loop_en
                   && (loop_start <= loop_end)
                   && ({1'b0, loop_end} < prog_len);

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        last_d    = last_q;
        lst_d     = lst_q;
        lend_d    = lend_q;
        lact_d    = lact_q;
        iter_d    = iter_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        cfg_err_d = cfg_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d      = '0;
                    busy_d    = 1'b1;
                    last_d    = prog_len - (AW+1)'(1);
                    lst_d     = loop_start;
                    lend_d    = loop_end;
                    lact_d    = cfg_act;
                    iter_d    = loop_count;
                    cfg_err_d = loop_en && !cfg_act;
                    state_d   = (prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!ext_stall) begin
                    if (lact_q && (pc_q == lend_q)
                        && (iter_q > CW'(1))) begin
                        iter_d  = iter_q - CW'(1);
                        pc_d    = lst_q;
                        state_d = S_FETCH;
                    end else if ({1'b0, pc_q} == last_q) begin
                        drain_d = DW'(DRAIN_CYCLES - 1);
                        state_d = S_DRAIN;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            last_q    <= '0;
            lst_q     <= '0;
            lend_q    <= '0;
            lact_q    <= 1'b0;
            iter_q    <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            last_q    <= last_d;
            lst_q     <= lst_d;
            lend_q    <= lend_d;
            lact_q    <= lact_d;
            iter_q    <= iter_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign pc          = pc_q;
    assign ins_rd_en   = (state_q == S_FETCH);
    assign issue_valid = (state_q == S_EXEC) && !ext_stall;
    assign done        = (state_q == S_DONE);
    assign busy        = busy_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_simd_sequencer.sv
// Randomized bench for simd_sequencer against a per-cycle trace model
// built from the expanded instruction list of each run.
module tb_simd_sequencer;

    localparam int AW = 4;
    localparam int CW = 3;
    localparam int DC = 3;
    localparam int PMAX = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] loop_start = '0;
    logic [AW-1:0] loop_end = '0;
    logic [CW-1:0] loop_count = '0;
    logic          ext_stall = 1'b0;
    logic [AW-1:0] pc;
    logic          ins_rd_en;
    logic          issue_valid;
    logic          busy;
    logic          done;
    logic          cfg_err;

    simd_sequencer #(
        .INS_ADDR_WIDTH(AW),
        .LOOP_CNT_WIDTH(CW),
        .DRAIN_CYCLES  (DC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .prog_len   (prog_len),
        .loop_en    (loop_en),
        .loop_start (loop_start),
        .loop_end   (loop_end),
        .loop_count (loop_count),
        .ext_stall  (ext_stall),
        .pc         (pc),
        .ins_rd_en  (ins_rd_en),
        .issue_valid(issue_valid),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        bit rd;
        bit iv;
        bit dn;
        bit bz;
        bit st;
        int pc;
    } cyc_t;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic scramble();
        prog_len   = (AW+1)'($urandom_range(PMAX));
        loop_en    = 1'($urandom_range(1));
        loop_start = AW'($urandom);
        loop_end   = AW'($urandom);
        loop_count = CW'($urandom);
    endtask

    // One complete run; fix_idx/fix_n force a stall length on one issue.
    task automatic run(input int len, input bit en,
                       input int ls, input int le, input int cnt,
                       input int stall_pct,
                       input int fix_idx, input int fix_n);
        int   pcs[$];
        cyc_t tr[$];
        bit   act;
        bit   eerr;
        int   reps;
        int   ns;
        int   lastpc;
        act  = en && (ls <= le) && (le < len);
        eerr = en && !act;
        if (act) begin
            reps = (cnt < 2) ? 1 : cnt;
            for (int p = 0; p < ls; p++) pcs.push_back(p);
            for (int r = 0; r < reps; r++)
                for (int p = ls; p <= le; p++) pcs.push_back(p);
            for (int p = le + 1; p < len; p++) pcs.push_back(p);
        end else begin
            for (int p = 0; p < len; p++) pcs.push_back(p);
        end
        lastpc = 0;
        foreach (pcs[k]) begin
            tr.push_back('{1, 0, 0, 1, 1'($urandom_range(1)), pcs[k]});
            if (k == fix_idx) ns = fix_n;
            else if (int'($urandom_range(99)) < stall_pct)
                ns = $urandom_range(1, 3);
            else ns = 0;
            repeat (ns) tr.push_back('{0, 0, 0, 1, 1, pcs[k]});
            tr.push_back('{0, 1, 0, 1, 0, pcs[k]});
            lastpc = pcs[k];
        end
        if (len > 0)
            repeat (DC) tr.push_back('{0, 0, 0, 1,
                                       1'($urandom_range(1)), lastpc});
        tr.push_back('{0, 0, 1, 1, 1'($urandom_range(1)), lastpc});
        tr.push_back('{0, 0, 0, 0, 0, lastpc});

        @(negedge clk);
        prog_len   = (AW+1)'(len);
        loop_en    = en;
        loop_start = AW'(ls);
        loop_end   = AW'(le);
        loop_count = CW'(cnt);
        start      = 1'b1;
        ext_stall  = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_iv", issue_valid, 0);
        foreach (tr[i]) begin
            @(negedge clk);
            ext_stall = tr[i].st;
            start = (i < tr.size() - 1) ? 1'($urandom_range(1)) : 1'b0;
            scramble();
            #1;
            chk("rd_en", ins_rd_en, tr[i].rd);
            chk("issue", issue_valid, tr[i].iv);
            chk("done", done, tr[i].dn);
            chk("busy", busy, tr[i].bz);
            chk("pc", 32'(pc), tr[i].pc);
            chk("cfg_err", cfg_err, eerr);
        end
        start     = 1'b0;
        ext_stall = 1'b0;
    endtask

    task automatic reset_abort();
        @(negedge clk);
        prog_len = 4;
        loop_en  = 1'b0;
        start    = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("abort_pre_iv", issue_valid, 1);
        chk("abort_pre_pc", 32'(pc), 2);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("abort_pc", 32'(pc), 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd", ins_rd_en, 0);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            #1;
            chk("abort_nodone", done, 0);
            chk("abort_idle", busy, 0);
        end
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_iv", issue_valid, 0);
        chk("rst_rd", ins_rd_en, 0);
        rstn = 1'b1;

        run(4, 0, 0, 0, 0, 0, -1, 0);
        run(6, 1, 1, 3, 3, 0, -1, 0);
        run(3, 0, 0, 0, 0, 0, 1, 5);
        run(0, 0, 0, 0, 0, 0, -1, 0);
        run(4, 1, 0, 7, 2, 0, -1, 0);
        reset_abort();
        run(5, 0, 0, 0, 0, 20, -1, 0);
        run(5, 1, 2, 2, 0, 0, -1, 0);
        run(5, 1, 2, 2, 1, 0, -1, 0);
        run(5, 1, 2, 2, 4, 0, -1, 0);
        run(PMAX, 1, PMAX - 1, PMAX - 1, 3, 10, -1, 0);
        run(PMAX, 0, 0, 0, 0, 10, -1, 0);
        run(1, 1, 0, 0, 7, 30, -1, 0);

        for (int n = 0; n < 30; n++) begin
            int len;
            int ls;
            int le;
            len = $urandom_range(PMAX);
            if ($urandom_range(3) != 0 && len > 0) begin
                ls = $urandom_range(len - 1);
                le = $urandom_range(ls, len - 1);
            end else begin
                ls = $urandom_range(PMAX - 1);
                le = $urandom_range(PMAX - 1);
            end
            run(len, 1'($urandom_range(1)), ls, le,
                $urandom_range((1 << CW) - 1), 25, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
